// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: load/store operation codes for the memory access unit.
package lc3b_types;

    typedef enum logic [2:0] {
        LDW = 3'd0,
        LDB = 3'd1,
        STW = 3'd2,
        STB = 3'd3,
        LDI = 3'd4,
        STI = 3'd5
    } lsu_op_t;

    function automatic logic is_indirect(input lsu_op_t op);
        return (op == LDI) || (op == STI);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-side handshake bundle of the memory access unit.
interface mem_access_unit_if
    import lc3b_types::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    lsu_op_t               req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [LANES-1:0]      mem_byte_enable;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    // Control path plus memory model side.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_rdata,
               mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );

    // The access unit itself.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_rdata,
               mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/byte_lane.sv
// Byte-lane steering: lane extraction with zero-extend, store-byte replication and one-hot enable.
module byte_lane #(
    parameter  int unsigned DATA_WIDTH = 16,
    localparam int unsigned LANES      = DATA_WIDTH / 8,
    localparam int unsigned LB         = $clog2(LANES)
) (
    input  logic [LB-1:0]         lane,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [7:0]            wbyte,
    output logic [DATA_WIDTH-1:0] rbyte_c,
    output logic [DATA_WIDTH-1:0] wdata_c,
    output logic [LANES-1:0]      be_c
);

    always_comb begin
        rbyte_c = '0;
        be_c    = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (lane == LB'(i)) begin
                rbyte_c = DATA_WIDTH'(rdata[i*8 +: 8]);
                be_c[i] = 1'b1;
            end
        end
    end

    assign wdata_c = {LANES{wbyte}};

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store engine: memory handshake, byte steering and two-phase indirect access.
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    localparam int unsigned           LANES      = DATA_WIDTH / 8;
    localparam int unsigned           LB         = $clog2(LANES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LANES - 1);

    typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

    state_t                state;
    lsu_op_t               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [LB-1:0]         lane_c;
    logic [DATA_WIDTH-1:0] lane_rdata_c;
    logic [DATA_WIDTH-1:0] lane_wdata_c;
    logic [LANES-1:0]      lane_be_c;
    logic [ADDR_WIDTH-1:0] ptr_c;

    // Store lanes are computed from the live request; load lanes from the latched address.
    assign lane_c = (state == IDLE) ? bus.req_addr[LB-1:0] : addr_q[LB-1:0];
    assign ptr_c  = ADDR_WIDTH'(bus.mem_rdata) & ALIGN_MASK;

    byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_byte_lane (
        .lane    (lane_c),
        .rdata   (bus.mem_rdata),
        .wbyte   (bus.req_wdata[7:0]),
        .rbyte_c (lane_rdata_c),
        .wdata_c (lane_wdata_c),
        .be_c    (lane_be_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            op_q                <= LDW;
            addr_q              <= '0;
            wdata_q             <= '0;
            bus.req_ready       <= 1'b1;
            bus.resp_valid      <= 1'b0;
            bus.resp_rdata      <= '0;
            bus.mem_address     <= '0;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= '0;
            bus.mem_wdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        case (bus.req_op)
                            LDW: begin
                                bus.mem_read    <= 1'b1;
                                bus.mem_address <= bus.req_addr & ALIGN_MASK;
                                state           <= ACCESS;
                            end
                            LDB: begin
                                bus.mem_read    <= 1'b1;
                                bus.mem_address <= bus.req_addr;
                                state           <= ACCESS;
                            end
                            STW: begin
                                bus.mem_write       <= 1'b1;
                                bus.mem_address     <= bus.req_addr & ALIGN_MASK;
                                bus.mem_wdata       <= bus.req_wdata;
                                bus.mem_byte_enable <= '1;
                                state               <= ACCESS;
                            end
                            STB: begin
                                bus.mem_write       <= 1'b1;
                                bus.mem_address     <= bus.req_addr;
                                bus.mem_wdata       <= lane_wdata_c;
                                bus.mem_byte_enable <= lane_be_c;
                                state               <= ACCESS;
                            end
                            LDI, STI: begin
                                bus.mem_read    <= 1'b1;
                                bus.mem_address <= bus.req_addr & ALIGN_MASK;
                                state           <= PTR;
                            end
                            default: begin
                                bus.resp_valid <= 1'b1;
                                bus.resp_rdata <= '0;
                                state          <= DONE;
                            end
                        endcase
                    end
                end
                PTR: begin
                    // Pointer word becomes the word-aligned target of the second phase.
                    if (bus.mem_resp) begin
                        addr_q          <= ptr_c;
                        bus.mem_address <= ptr_c;
                        state           <= ACCESS;
                        if (op_q == STI) begin
                            bus.mem_read        <= 1'b0;
                            bus.mem_write       <= 1'b1;
                            bus.mem_wdata       <= wdata_q;
                            bus.mem_byte_enable <= '1;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_resp) begin
                        bus.mem_read        <= 1'b0;
                        bus.mem_write       <= 1'b0;
                        bus.mem_byte_enable <= '0;
                        bus.resp_valid      <= 1'b1;
                        state               <= DONE;
                        case (op_q)
                            LDW, LDI: bus.resp_rdata <= bus.mem_rdata;
                            LDB:      bus.resp_rdata <= lane_rdata_c;
                            default:  bus.resp_rdata <= '0;
                        endcase
                    end
                end
                DONE: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a word-array memory model.
module tb_mem_access_unit;
    import lc3b_types::*;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [int];

    mem_access_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();
    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();

    mem_access_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ram_rd(input logic [15:0] a);
        int k;
        k = int'(a >> 1);
        if (!ram.exists(k)) ram[k] = 16'($urandom);
        return ram[k];
    endfunction

    task automatic ram_wr(input logic [15:0] a, input logic [15:0] d);
        ram[int'(a >> 1)] = d;
    endtask

    // One complete operation on the 16-bit unit, acting as memory and checking every cycle.
    task automatic do_op(input logic [2:0] opv, input logic [15:0] addr, input logic [15:0] wdata,
                         input int ptr_wait, input int acc_wait);
        logic [15:0] acc_addr;
        logic [15:0] word;
        logic [15:0] exp_rdata;
        logic [15:0] exp_wdata;
        logic [15:0] cur;
        logic [1:0]  exp_be;
        logic        is_ld;
        int          n;

        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk1("ready_idle", bus.req_ready, 1'b1);

        bus.req_valid = 1'b1;
        bus.req_op    = lsu_op_t'(opv);
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = lsu_op_t'($urandom_range(0, 7));
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        chk1("ready_busy", bus.req_ready, 1'b0);

        if (opv > 3'd5) begin
            chk1("nop_resp_valid", bus.resp_valid, 1'b1);
            chkw("nop_rdata", 64'(bus.resp_rdata), 64'(16'h0000));
            chk1("nop_read", bus.mem_read, 1'b0);
            chk1("nop_write", bus.mem_write, 1'b0);
            tick();
            chk1("nop_resp_drop", bus.resp_valid, 1'b0);
            chk1("nop_ready", bus.req_ready, 1'b1);
            return;
        end

        acc_addr = addr;
        if (opv == 3'd4 || opv == 3'd5) begin
            for (int i = 0; i <= ptr_wait; i++) begin
                chk1("ptr_read", bus.mem_read, 1'b1);
                chk1("ptr_write", bus.mem_write, 1'b0);
                chkw("ptr_addr", 64'(bus.mem_address), 64'(addr & 16'hFFFE));
                bus.mem_resp  = (i == ptr_wait);
                bus.mem_rdata = (i == ptr_wait) ? ram_rd(addr) : 16'($urandom);
                tick();
            end
            bus.mem_resp = 1'b0;
            acc_addr = ram_rd(addr);
        end

        is_ld = (opv == 3'd0) || (opv == 3'd1) || (opv == 3'd4);
        word  = ram_rd(acc_addr);
        case (opv)
            3'd0, 3'd4: exp_rdata = word;
            3'd1:       exp_rdata = acc_addr[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
            default:    exp_rdata = 16'h0000;
        endcase
        exp_wdata = (opv == 3'd3) ? {2{wdata[7:0]}} : wdata;
        exp_be    = (opv == 3'd3) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;

        for (int i = 0; i <= acc_wait; i++) begin
            chk1("acc_read", bus.mem_read, is_ld);
            chk1("acc_write", bus.mem_write, !is_ld);
            if (opv == 3'd1)
                chkw("acc_addr_byte", 64'(bus.mem_address), 64'(acc_addr));
            else if (opv == 3'd3)
                chkw("acc_addr_stb", 64'(bus.mem_address[15:1]), 64'(acc_addr[15:1]));
            else
                chkw("acc_addr_word", 64'(bus.mem_address), 64'(acc_addr & 16'hFFFE));
            if (!is_ld) begin
                chkw("acc_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
                chkw("acc_be", 64'(bus.mem_byte_enable), 64'(exp_be));
            end else begin
                chkw("acc_be_load", 64'(bus.mem_byte_enable), 64'(2'b00));
            end
            bus.mem_resp  = (i == acc_wait);
            bus.mem_rdata = (i == acc_wait && is_ld) ? word : 16'($urandom);
            tick();
        end

        if (opv == 3'd2 || opv == 3'd5) begin
            ram_wr(acc_addr, wdata);
        end else if (opv == 3'd3) begin
            cur = ram_rd(acc_addr);
            if (acc_addr[0]) cur[15:8] = wdata[7:0];
            else             cur[7:0]  = wdata[7:0];
            ram_wr(acc_addr, cur);
        end

        // Stray mem_resp during completion must be ignored.
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'($urandom);
        chk1("done_resp_valid", bus.resp_valid, 1'b1);
        chkw("done_rdata", 64'(bus.resp_rdata), 64'(exp_rdata));
        chk1("done_read", bus.mem_read, 1'b0);
        chk1("done_write", bus.mem_write, 1'b0);
        chkw("done_be", 64'(bus.mem_byte_enable), 64'(2'b00));
        chk1("done_ready", bus.req_ready, 1'b0);
        tick();
        bus.mem_resp = 1'b0;
        chk1("post_resp_valid", bus.resp_valid, 1'b0);
        chk1("post_ready", bus.req_ready, 1'b1);
        chk1("post_read", bus.mem_read, 1'b0);
        chk1("post_write", bus.mem_write, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = LDW;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.mem_rdata   = '0;
        bus.mem_resp    = 1'b0;
        bus32.req_valid = 1'b0;
        bus32.req_op    = LDW;
        bus32.req_addr  = '0;
        bus32.req_wdata = '0;
        bus32.mem_rdata = '0;
        bus32.mem_resp  = 1'b0;
        tick();
        tick();

        chk1("rst_ready", bus.req_ready, 1'b1);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chk1("rst_read", bus.mem_read, 1'b0);
        chk1("rst_write", bus.mem_write, 1'b0);
        chkw("rst_be", 64'(bus.mem_byte_enable), 64'(2'b00));
        chkw("rst_addr", 64'(bus.mem_address), 64'(16'h0000));
        chkw("rst_wdata", 64'(bus.mem_wdata), 64'(16'h0000));
        chkw("rst_rdata", 64'(bus.resp_rdata), 64'(16'h0000));
        chk1("rst32_ready", bus32.req_ready, 1'b1);
        chkw("rst32_be", 64'(bus32.mem_byte_enable), 64'(4'b0000));
        rst_n = 1'b1;
        tick();

        ram_wr(16'h1234, 16'hBEEF);
        do_op(3'd0, 16'h1235, 16'h0000, 0, 0);
        ram_wr(16'h2000, 16'hA55A);
        do_op(3'd1, 16'h2001, 16'h0000, 0, 0);
        do_op(3'd1, 16'h2000, 16'h0000, 0, 1);
        do_op(3'd3, 16'h3001, 16'h00C3, 0, 0);
        do_op(3'd3, 16'h3000, 16'h7E5A, 0, 2);
        do_op(3'd2, 16'h3003, 16'h9876, 0, 1);
        ram_wr(16'h4000, 16'h5006);
        do_op(3'd5, 16'h4000, 16'h1357, 3, 1);
        do_op(3'd4, 16'h4001, 16'h0000, 1, 0);
        do_op(3'd6, 16'h1111, 16'h2222, 0, 0);
        do_op(3'd7, 16'h3333, 16'h4444, 0, 0);

        // Reset during an access wait aborts the operation.
        bus.req_valid = 1'b1;
        bus.req_op    = LDW;
        bus.req_addr  = 16'h0200;
        tick();
        bus.req_valid = 1'b0;
        chk1("abort_strobe_up", bus.mem_read, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk1("abort_read", bus.mem_read, 1'b0);
        chk1("abort_write", bus.mem_write, 1'b0);
        chk1("abort_ready", bus.req_ready, 1'b1);
        chk1("abort_resp_valid", bus.resp_valid, 1'b0);
        rst_n = 1'b1;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_resp = 1'b0;
        chk1("late_resp_valid", bus.resp_valid, 1'b0);
        chk1("late_read", bus.mem_read, 1'b0);
        tick();
        chk1("late_resp_valid2", bus.resp_valid, 1'b0);
        chk1("late_ready", bus.req_ready, 1'b1);

        for (int t = 0; t < 40; t++) begin
            do_op(3'($urandom_range(0, 7)),
                  16'h0100 + 16'($urandom_range(0, 15)),
                  16'($urandom),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        // 32-bit instance: byte load from the top lane, byte store into lane 2.
        bus32.req_valid = 1'b1;
        bus32.req_op    = LDB;
        bus32.req_addr  = 32'h0000_2003;
        tick();
        bus32.req_valid = 1'b0;
        chk1("w32_ldb_read", bus32.mem_read, 1'b1);
        chkw("w32_ldb_addr", 64'(bus32.mem_address), 64'(32'h0000_2003));
        bus32.mem_resp  = 1'b1;
        bus32.mem_rdata = 32'h1122_3344;
        tick();
        bus32.mem_resp  = 1'b0;
        chk1("w32_ldb_resp_valid", bus32.resp_valid, 1'b1);
        chkw("w32_ldb_rdata", 64'(bus32.resp_rdata), 64'(32'h0000_0011));
        tick();
        chk1("w32_ldb_ready", bus32.req_ready, 1'b1);
        bus32.req_valid = 1'b1;
        bus32.req_op    = STB;
        bus32.req_addr  = 32'h0000_0102;
        bus32.req_wdata = 32'h0000_00AB;
        tick();
        bus32.req_valid = 1'b0;
        chk1("w32_stb_write", bus32.mem_write, 1'b1);
        chkw("w32_stb_wdata", 64'(bus32.mem_wdata), 64'(32'hABAB_ABAB));
        chkw("w32_stb_be", 64'(bus32.mem_byte_enable), 64'(4'b0100));
        bus32.mem_resp = 1'b1;
        tick();
        bus32.mem_resp = 1'b0;
        chk1("w32_stb_resp_valid", bus32.resp_valid, 1'b1);
        chkw("w32_stb_rdata", 64'(bus32.resp_rdata), 64'(32'h0000_0000));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
